// File: rtl/id_stage.sv
// rtl/id_stage.sv - ARM instruction decode stage with register file and ID/EX pipeline register
module id_stage #(
    parameter int WIDTH     = 32,
    parameter int REG_COUNT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] if_pc,
    input  logic [31:0]      if_instr,
    input  logic [3:0]       status,
    input  logic             freeze,
    input  logic             flush,
    input  logic             wb_wb_en,
    input  logic [3:0]       wb_dest,
    input  logic [WIDTH-1:0] wb_value,
    output logic [WIDTH-1:0] id_pc,
    output logic             id_valid,
    output logic [3:0]       id_exe_cmd,
    output logic             id_mem_r,
    output logic             id_mem_w,
    output logic             id_wb_en,
    output logic             id_b,
    output logic             id_s,
    output logic [WIDTH-1:0] id_val_rn,
    output logic [WIDTH-1:0] id_val_rm,
    output logic             id_imm,
    output logic [11:0]      id_shift_operand,
    output logic [23:0]      id_signed_imm_24,
    output logic [3:0]       id_dest,
    output logic [3:0]       id_src1,
    output logic [3:0]       id_src2
);

    logic [WIDTH-1:0] regs [REG_COUNT];

    logic [1:0]       mode;
    logic [3:0]       opcode;
    logic [3:0]       dec_cmd;
    logic             dec_mem_r;
    logic             dec_mem_w;
    logic             dec_wb_en;
    logic             dec_b;
    logic             dec_s;
    logic             cond_pass;
    logic [3:0]       src1;
    logic [3:0]       src2;
    logic [WIDTH-1:0] val_rn;
    logic [WIDTH-1:0] val_rm;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    assign mode   = if_instr[27:26];
    assign opcode = if_instr[24:21];
    assign {flag_n, flag_z, flag_c, flag_v} = status;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_wb_en && int'(wb_dest) < REG_COUNT) begin
            regs[wb_dest] <= wb_value;
        end
    end

    always_comb begin
        dec_cmd   = 4'b0000;
        dec_mem_r = 1'b0;
        dec_mem_w = 1'b0;
        dec_wb_en = 1'b0;
        dec_b     = 1'b0;
        dec_s     = 1'b0;
        case (mode)
            2'b00: begin
                dec_s = if_instr[20];
                case (opcode)
                    4'b1101: begin dec_cmd = 4'b0001; dec_wb_en = 1'b1; end
                    4'b1111: begin dec_cmd = 4'b1001; dec_wb_en = 1'b1; end
                    4'b0100: begin dec_cmd = 4'b0010; dec_wb_en = 1'b1; end
                    4'b0101: begin dec_cmd = 4'b0011; dec_wb_en = 1'b1; end
                    4'b0010: begin dec_cmd = 4'b0100; dec_wb_en = 1'b1; end
                    4'b0110: begin dec_cmd = 4'b0101; dec_wb_en = 1'b1; end
                    4'b0000: begin dec_cmd = 4'b0110; dec_wb_en = 1'b1; end
                    4'b1100: begin dec_cmd = 4'b0111; dec_wb_en = 1'b1; end
                    4'b0001: begin dec_cmd = 4'b1000; dec_wb_en = 1'b1; end
                    4'b1010: dec_cmd = 4'b0100;
                    4'b1000: dec_cmd = 4'b0110;
                    default: dec_s = 1'b0;
                endcase
            end
            2'b01: begin
                dec_cmd = 4'b0010;
                if (if_instr[20]) begin
                    dec_mem_r = 1'b1;
                    dec_wb_en = 1'b1;
                end else begin
                    dec_mem_w = 1'b1;
                end
            end
            2'b10: dec_b = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cond_pass = 1'b0;
        case (if_instr[31:28])
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Store data register sits in Rd, so hazard logic must see it as the second source.
    assign src1 = if_instr[19:16];
    assign src2 = dec_mem_w ? if_instr[15:12] : if_instr[3:0];

    always_comb begin
        val_rn = '0;
        if (int'(src1) < REG_COUNT) begin
            val_rn = (wb_wb_en && wb_dest == src1) ? wb_value : regs[src1];
        end
    end

    always_comb begin
        val_rm = '0;
        if (int'(src2) < REG_COUNT) begin
            val_rm = (wb_wb_en && wb_dest == src2) ? wb_value : regs[src2];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            id_pc            <= '0;
            id_valid         <= 1'b0;
            id_exe_cmd       <= 4'b0000;
            id_mem_r         <= 1'b0;
            id_mem_w         <= 1'b0;
            id_wb_en         <= 1'b0;
            id_b             <= 1'b0;
            id_s             <= 1'b0;
            id_val_rn        <= '0;
            id_val_rm        <= '0;
            id_imm           <= 1'b0;
            id_shift_operand <= 12'h000;
            id_signed_imm_24 <= 24'h000000;
            id_dest          <= 4'h0;
            id_src1          <= 4'h0;
            id_src2          <= 4'h0;
        end else if (!freeze) begin
            id_pc            <= if_pc;
            id_valid         <= 1'b1;
            id_exe_cmd       <= cond_pass ? dec_cmd : 4'b0000;
            id_mem_r         <= cond_pass && dec_mem_r;
            id_mem_w         <= cond_pass && dec_mem_w;
            id_wb_en         <= cond_pass && dec_wb_en;
            id_b             <= cond_pass && dec_b;
            id_s             <= cond_pass && dec_s;
            id_val_rn        <= val_rn;
            id_val_rm        <= val_rm;
            id_imm           <= if_instr[25];
            id_shift_operand <= if_instr[11:0];
            id_signed_imm_24 <= if_instr[23:0];
            id_dest          <= if_instr[15:12];
            id_src1          <= src1;
            id_src2          <= src2;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage with randomized reference-model comparison
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_instr = '0;
    logic [3:0]  status = '0;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        wb_wb_en = 1'b0;
    logic [3:0]  wb_dest = '0;
    logic [31:0] wb_value = '0;

    logic [31:0] id_pc;
    logic        id_valid;
    logic [3:0]  id_exe_cmd;
    logic        id_mem_r, id_mem_w, id_wb_en, id_b, id_s;
    logic [31:0] id_val_rn, id_val_rm;
    logic        id_imm;
    logic [11:0] id_shift_operand;
    logic [23:0] id_signed_imm_24;
    logic [3:0]  id_dest, id_src1, id_src2;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [3:0]  cmd;
        logic        mem_r;
        logic        mem_w;
        logic        wb_en;
        logic        b;
        logic        s;
        logic [31:0] rn;
        logic [31:0] rm;
        logic        imm;
        logic [11:0] shift;
        logic [23:0] simm;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } out_t;

    out_t        dut_o;
    out_t        exp_o;
    logic [31:0] mregs [15];
    int          checks = 0;
    int          fails = 0;

    assign dut_o = {id_pc, id_valid, id_exe_cmd, id_mem_r, id_mem_w, id_wb_en, id_b, id_s,
                    id_val_rn, id_val_rm, id_imm, id_shift_operand, id_signed_imm_24,
                    id_dest, id_src1, id_src2};

    id_stage #(.WIDTH(32), .REG_COUNT(15)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr), .status(status),
        .freeze(freeze), .flush(flush), .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
        .wb_value(wb_value), .id_pc(id_pc), .id_valid(id_valid), .id_exe_cmd(id_exe_cmd),
        .id_mem_r(id_mem_r), .id_mem_w(id_mem_w), .id_wb_en(id_wb_en), .id_b(id_b),
        .id_s(id_s), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
        .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
        .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mread(input logic [3:0] idx);
        if (idx == 4'd15) return 32'h0;
        if (wb_wb_en && wb_dest == idx) return wb_value;
        return mregs[idx];
    endfunction

    function automatic out_t model_decode();
        out_t d;
        logic n, z, c, v, pass, known;
        d = '0;
        {n, z, c, v} = status;
        case (if_instr[31:28])
            4'h0: pass = z;         4'h1: pass = !z;
            4'h2: pass = c;         4'h3: pass = !c;
            4'h4: pass = n;         4'h5: pass = !n;
            4'h6: pass = v;         4'h7: pass = !v;
            4'h8: pass = c && !z;   4'h9: pass = !c || z;
            4'hA: pass = n == v;    4'hB: pass = n != v;
            4'hC: pass = !z && n == v;
            4'hD: pass = z || n != v;
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        d.pc = if_pc;
        d.valid = 1'b1;
        d.imm = if_instr[25];
        d.shift = if_instr[11:0];
        d.simm = if_instr[23:0];
        d.dest = if_instr[15:12];
        d.src1 = if_instr[19:16];
        known = 1'b1;
        if (if_instr[27:26] == 2'b00) begin
            d.wb_en = 1'b1;
            case (if_instr[24:21])
                4'b1101: d.cmd = 4'd1;  4'b1111: d.cmd = 4'd9;
                4'b0100: d.cmd = 4'd2;  4'b0101: d.cmd = 4'd3;
                4'b0010: d.cmd = 4'd4;  4'b0110: d.cmd = 4'd5;
                4'b0000: d.cmd = 4'd6;  4'b1100: d.cmd = 4'd7;
                4'b0001: d.cmd = 4'd8;
                4'b1010: begin d.cmd = 4'd4; d.wb_en = 1'b0; end
                4'b1000: begin d.cmd = 4'd6; d.wb_en = 1'b0; end
                default: begin known = 1'b0; d.wb_en = 1'b0; end
            endcase
            d.s = known && if_instr[20];
        end else if (if_instr[27:26] == 2'b01) begin
            d.cmd = 4'd2;
            d.mem_r = if_instr[20];
            d.wb_en = if_instr[20];
            d.mem_w = !if_instr[20];
        end else if (if_instr[27:26] == 2'b10) begin
            d.b = 1'b1;
        end
        d.src2 = d.mem_w ? if_instr[15:12] : if_instr[3:0];
        d.rn = mread(d.src1);
        d.rm = mread(d.src2);
        if (!pass) {d.cmd, d.mem_r, d.mem_w, d.wb_en, d.b, d.s} = '0;
        return d;
    endfunction

    task automatic step();
        out_t d;
        d = model_decode();
        if (wb_wb_en && wb_dest != 4'd15) mregs[wb_dest] = wb_value;
        if (flush) exp_o = '0;
        else if (!freeze) exp_o = d;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) mregs[i] = '0;
        exp_o = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (dut_o !== '0) begin fails++; $display("FAIL reset_outputs got %h want 0", dut_o); end
        rst = 1'b1;
    endtask

    task automatic test_write_through();
        if_pc = 32'h4;
        wb_wb_en = 1'b1; wb_dest = 4'd1; wb_value = 32'h0000000A; if_instr = 32'h0;
        step();
        wb_wb_en = 1'b0; if_instr = 32'hE0802001; if_pc = 32'h8;
        step();
        checks++;
        if ({id_exe_cmd, id_wb_en, id_dest, id_src1, id_src2} !== {4'b0010, 1'b1, 4'd2, 4'd0, 4'd1}) begin
            fails++;
            $display("FAIL add_ctrl got cmd=%b wb=%b d=%0d s1=%0d s2=%0d want 0010 1 2 0 1",
                     id_exe_cmd, id_wb_en, id_dest, id_src1, id_src2);
        end
        checks++;
        if (id_val_rm !== 32'hA || id_val_rn !== 32'h0) begin
            fails++; $display("FAIL add_operands got rn=%h rm=%h want 0 a", id_val_rn, id_val_rm);
        end
        wb_wb_en = 1'b1; wb_dest = 4'd0; wb_value = 32'h55;
        step();
        checks++;
        if (id_val_rn !== 32'h55) begin fails++; $display("FAIL write_through got %h want 55", id_val_rn); end
        wb_wb_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dut_o !== '0) begin fails++; $display("FAIL async_reset got %h want 0", dut_o); end
        rst = 1'b1;
        model_reset();
        step();
        checks++;
        if (id_val_rm !== 32'h0 || id_valid !== 1'b1) begin
            fails++; $display("FAIL reg_cleared got rm=%h valid=%b want 0 1", id_val_rm, id_valid);
        end
    endtask

    task automatic test_mov_imm();
        if_instr = 32'hE3A0100A;
        step();
        checks++;
        if ({id_exe_cmd, id_imm, id_shift_operand, id_wb_en, id_dest} !== {4'b0001, 1'b1, 12'h00A, 1'b1, 4'd1}) begin
            fails++;
            $display("FAIL mov_imm got cmd=%b i=%b sh=%h wb=%b d=%0d want 0001 1 00a 1 1",
                     id_exe_cmd, id_imm, id_shift_operand, id_wb_en, id_dest);
        end
    endtask

    task automatic test_mem();
        if_instr = 32'hE5912004;
        step();
        checks++;
        if ({id_mem_r, id_mem_w, id_wb_en, id_exe_cmd} !== {1'b1, 1'b0, 1'b1, 4'b0010}) begin
            fails++; $display("FAIL ldr got r=%b w=%b wb=%b cmd=%b want 1 0 1 0010",
                              id_mem_r, id_mem_w, id_wb_en, id_exe_cmd);
        end
        if_instr = 32'hE5812004;
        step();
        checks++;
        if ({id_mem_r, id_mem_w, id_wb_en, id_src2} !== {1'b0, 1'b1, 1'b0, 4'd2}) begin
            fails++; $display("FAIL str got r=%b w=%b wb=%b s2=%0d want 0 1 0 2",
                              id_mem_r, id_mem_w, id_wb_en, id_src2);
        end
    endtask

    task automatic test_cond();
        if_instr = 32'h03A0100A; status = 4'b0000;
        step();
        checks++;
        if ({id_exe_cmd, id_mem_r, id_mem_w, id_wb_en, id_b, id_s, id_valid} !== {4'b0, 5'b0, 1'b1}) begin
            fails++; $display("FAIL eq_fail got cmd=%b wb=%b valid=%b want 0 0 1", id_exe_cmd, id_wb_en, id_valid);
        end
        status = 4'b0100;
        step();
        checks++;
        if (id_wb_en !== 1'b1 || id_exe_cmd !== 4'b0001) begin
            fails++; $display("FAIL eq_pass got wb=%b cmd=%b want 1 0001", id_wb_en, id_exe_cmd);
        end
        status = 4'b0000;
    endtask

    task automatic test_branch_freeze_flush();
        if_instr = 32'hEAFFFFFE; if_pc = 32'h100;
        step();
        checks++;
        if (id_b !== 1'b1 || id_signed_imm_24 !== 24'hFFFFFE || id_wb_en !== 1'b0) begin
            fails++; $display("FAIL branch got b=%b imm=%h wb=%b want 1 fffffe 0", id_b, id_signed_imm_24, id_wb_en);
        end
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_instr = $urandom; if_pc = $urandom;
            step();
            checks++;
            if ({id_b, id_signed_imm_24, id_pc, id_valid} !== {1'b1, 24'hFFFFFE, 32'h100, 1'b1}) begin
                fails++; $display("FAIL freeze_hold cycle %0d got b=%b imm=%h pc=%h want 1 fffffe 100",
                                  i, id_b, id_signed_imm_24, id_pc);
            end
        end
        flush = 1'b1;
        step();
        checks++;
        if (dut_o !== '0) begin fails++; $display("FAIL flush_over_freeze got %h want 0", dut_o); end
        flush = 1'b0; freeze = 1'b0;
    endtask

    task automatic test_random();
        rst = 1'b0;
        #1 model_reset();
        rst = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if_pc = $urandom;
            if_instr = $urandom;
            if ($urandom_range(0, 3) == 0) if_instr[31:28] = 4'hE;
            status = 4'($urandom);
            wb_wb_en = 1'($urandom);
            wb_dest = 4'($urandom);
            if ($urandom_range(0, 3) == 0) wb_dest = if_instr[19:16];
            wb_value = $urandom;
            freeze = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 11) == 0);
            step();
            checks++;
            if (dut_o !== exp_o) begin
                fails++; $display("FAIL random_%0d got %h want %h", i, dut_o, exp_o);
            end
        end
        freeze = 1'b0; flush = 1'b0; wb_wb_en = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_through();
        test_mov_imm();
        test_mem();
        test_cond();
        test_branch_freeze_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
